// File: rtl/avrspi_slave.sv
// avrspi_slave: fabric-side SPI mode-0 slave for the AVR link.
// All pins are oversampled in the fclk domain. Received bytes are presented
// as a one-cycle strobe. A response byte from a holding register is shifted
// back on spidi, MSB first.
// Optional feature macro: AVRSPI_TXBUF_EN adds a valid flag on the holding
// register, plus tx_empty/tx_underrun outputs. Underrun bytes are sent as 0xFF.
module avrspi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       spics_n,
  input  logic       spick,
  input  logic       spido,
  output logic       spidi,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  output logic       rx_first,
  output logic       cs_start,
  output logic       cs_end,
  input  logic [7:0] tx_data,
  input  logic       tx_load
`ifdef AVRSPI_TXBUF_EN
  ,
  output logic       tx_empty,
  output logic       tx_underrun
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] cs_sync, ck_sync, do_sync;
  logic                   cs_hist, ck_hist;
  logic                   cs_s, ck_s, do_s;
  logic                   cs_fall, cs_rise, ck_rise, ck_fall;
  logic                   enter, leave, reload;
  logic [7:0]             hold, hold_nxt, reload_val;
  logic [7:0]             tx_shift;
  logic [6:0]             rx_shift;
  logic [2:0]             bit_cnt;
  logic                   first_flag;
`ifdef AVRSPI_TXBUF_EN
  logic                   hold_vld;
  logic                   underrun;
`endif

  // Pin synchronizers plus history flops. These are not reset, so that no
  // phantom edge appears when rst releases.
  always_ff @(posedge fclk) begin
    cs_sync <= {cs_sync[SYNC_STAGES-2:0], spics_n};
    ck_sync <= {ck_sync[SYNC_STAGES-2:0], spick};
    do_sync <= {do_sync[SYNC_STAGES-2:0], spido};
    cs_hist <= cs_sync[SYNC_STAGES-1];
    ck_hist <= ck_sync[SYNC_STAGES-1];
  end

  // Edge detection on the synchronized pins.
  always_comb begin
    cs_s    = cs_sync[SYNC_STAGES-1];
    ck_s    = ck_sync[SYNC_STAGES-1];
    do_s    = do_sync[SYNC_STAGES-1];
    cs_fall = cs_hist & ~cs_s;
    cs_rise = ~cs_hist & cs_s;
    ck_rise = ~ck_hist & ck_s;
    ck_fall = ck_hist & ~ck_s;
  end

  // Frame FSM next state, tx reload decision and MISO output.
  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    leave     = 1'b0;
    case (state)
      IDLE:   if (cs_fall) begin state_nxt = ACTIVE; enter = 1'b1; end
      ACTIVE: if (cs_rise) begin state_nxt = IDLE;   leave = 1'b1; end
      default: state_nxt = IDLE;
    endcase
    // A tx_load in the reload cycle is what gets shifted out.
    hold_nxt = tx_load ? tx_data : hold;
    reload   = enter | ((state == ACTIVE) & ~cs_rise & ck_fall & (bit_cnt == 3'd0));
`ifdef AVRSPI_TXBUF_EN
    reload_val = (tx_load | hold_vld) ? hold_nxt : 8'hFF;
    underrun   = reload & ~tx_load & ~hold_vld;
    tx_empty   = ~hold_vld;
`else
    reload_val = hold_nxt;
`endif
    spidi = (state == ACTIVE) ? tx_shift[7] : 1'b1;
  end

  // Frame state register.
  always_ff @(posedge fclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Shift registers, bit counter, holding register and output strobes.
  always_ff @(posedge fclk) begin
    if (rst) begin
      rx_data    <= 8'h00;
      rx_stb     <= 1'b0;
      rx_first   <= 1'b0;
      cs_start   <= 1'b0;
      cs_end     <= 1'b0;
      hold       <= 8'hFF;
      tx_shift   <= 8'h00;
      rx_shift   <= 7'h00;
      bit_cnt    <= 3'd0;
      first_flag <= 1'b0;
`ifdef AVRSPI_TXBUF_EN
      hold_vld    <= 1'b0;
      tx_underrun <= 1'b0;
`endif
    end else begin
      rx_stb   <= 1'b0;
      rx_first <= 1'b0;
      cs_start <= cs_fall;
      cs_end   <= cs_rise;
      hold     <= hold_nxt;
`ifdef AVRSPI_TXBUF_EN
      tx_underrun <= underrun;
      if (reload)       hold_vld <= 1'b0;
      else if (tx_load) hold_vld <= 1'b1;
`endif
      if (reload)
        tx_shift <= reload_val;
      else if ((state == ACTIVE) && !cs_rise && ck_fall)
        tx_shift <= {tx_shift[6:0], 1'b1};

      if (enter) begin
        bit_cnt    <= 3'd0;
        rx_shift   <= 7'h00;
        first_flag <= 1'b1;
      end else if (leave) begin
        // Partial byte is dropped; a cs rise beats a same-cycle 8th spick rise.
        bit_cnt  <= 3'd0;
        rx_shift <= 7'h00;
      end else if ((state == ACTIVE) && ck_rise) begin
        rx_shift <= {rx_shift[5:0], do_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data    <= {rx_shift, do_s};
          rx_stb     <= 1'b1;
          rx_first   <= first_flag;
          first_flag <= 1'b0;
        end
      end
    end
  end

endmodule
